pipe_fwd_chain: RTL and testbench

PIPE_FWD_CHAIN -- requirements
Module: pipe_fwd_chain

---
 rtl/pipe_fwd_chain_pkg.sv | 19 +
 rtl/pipe_fwd_chain_fwd_mux.sv | 46 ++++
 rtl/pipe_fwd_chain.sv | 150 +++++++++++++++
 tb/tb_pipe_fwd_chain.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_fwd_chain_pkg.sv
// Shared definitions for the writeback/forwarding chain: stage-count limit,
// register-zero address, default widths and register bus types.
package pipe_fwd_chain_pkg;

    localparam int STAGES_MAX       = 8;
    localparam int DEFAULT_DW       = 32;
    localparam int DEFAULT_AW       = 5;
    localparam int DEFAULT_RD_PORTS = 2;
    localparam int ADDR_ZERO        = 0;

    typedef logic [DEFAULT_DW-1:0] reg_bus_t;
    typedef logic [DEFAULT_AW-1:0] reg_addr_bus_t;

    // Saturating 32-bit increment: sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/pipe_fwd_chain_fwd_mux.sv
// Single read-port forwarding selector. Candidate 0 is the youngest result
// (the execute-stage input); the lowest-index matching candidate wins.
module pipe_fwd_chain_fwd_mux
    import pipe_fwd_chain_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int AW    = DEFAULT_AW,
    parameter int NCAND = 4
) (
    input  logic [NCAND-1:0]    cand_we,
    input  logic [NCAND*AW-1:0] cand_wd,
    input  logic [NCAND*DW-1:0] cand_wdata,
    input  logic [AW-1:0]       raddr,
    input  logic [DW-1:0]       rf_rdata,
    output logic [DW-1:0]       rdata,
    output logic                hit
);

    logic [DW-1:0] sel_data_s;
    logic          sel_hit_s;
    logic          match_s;

    // Priority match: scan oldest to youngest so the youngest match is the last writer.
    always_comb begin
        sel_data_s = rf_rdata;
        sel_hit_s  = 1'b0;
        match_s    = 1'b0;
        for (int i = NCAND - 1; i >= 0; i--) begin
            match_s    = cand_we[i] & (cand_wd[i*AW +: AW] == raddr);
            sel_data_s = match_s ? cand_wdata[i*DW +: DW] : sel_data_s;
            sel_hit_s  = sel_hit_s | match_s;
        end
    end

    // Register zero is hard-wired: it never forwards and always reads as zero.
    always_comb begin
        if (raddr == AW'(ADDR_ZERO)) begin
            rdata = {DW{1'b0}};
            hit   = 1'b0;
        end else begin
            rdata = sel_data_s;
            hit   = sel_hit_s;
        end
    end

endmodule

// File: rtl/pipe_fwd_chain.sv
// Writeback-carrying pipeline chain with per-stage stall/flush, regfile write
// port from the last stage and combinational operand forwarding.
module pipe_fwd_chain
    import pipe_fwd_chain_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int DW       = DEFAULT_DW,
    parameter int AW       = DEFAULT_AW,
    parameter int RD_PORTS = DEFAULT_RD_PORTS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_wreg,
    input  logic [AW-1:0]          in_wd,
    input  logic [DW-1:0]          in_wdata,
    output logic                   in_ready,
    input  logic [STAGES-1:0]      stall,
    input  logic                   flush,
    input  logic [RD_PORTS*AW-1:0] raddr,
    input  logic [RD_PORTS*DW-1:0] rf_rdata,
    output logic [RD_PORTS*DW-1:0] fwd_rdata,
    output logic [RD_PORTS-1:0]    fwd_hit,
    output logic                   wb_we,
    output logic [AW-1:0]          wb_wd,
    output logic [DW-1:0]          wb_wdata,
    output logic [31:0]            stall_cnt
);

    localparam int NCAND = STAGES + 1;

    if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_stages_illegal
        $error("pipe_fwd_chain: STAGES out of range");
    end

    logic [STAGES-1:0]   valid_r;
    logic [STAGES-1:0]   wreg_r;
    logic [AW-1:0]       wd_r    [STAGES];
    logic [DW-1:0]       wdata_r [STAGES];
    logic [31:0]         stall_cnt_r;
    logic [STAGES-1:0]   hold_s;
    logic                ready_s;
    logic [NCAND-1:0]    cand_we_s;
    logic [NCAND*AW-1:0] cand_wd_s;
    logic [NCAND*DW-1:0] cand_wdata_s;

    // Effective hold: a stall in any older stage freezes every younger stage.
    always_comb begin
        logic acc;
        acc    = 1'b0;
        hold_s = {STAGES{1'b0}};
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc       = acc | stall[k];
            hold_s[k] = acc;
        end
    end

    assign ready_s  = ~hold_s[0] & ~flush;
    assign in_ready = ready_s;

    // Stage registers: flush beats hold, hold beats bubble, otherwise shift forward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {STAGES{1'b0}};
            wreg_r  <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                wd_r[k]    <= {AW{1'b0}};
                wdata_r[k] <= {DW{1'b0}};
            end
        end else begin
            if (flush) begin
                valid_r[0] <= 1'b0;
                wreg_r[0]  <= 1'b0;
            end else if (hold_s[0]) begin
                valid_r[0] <= valid_r[0];
            end else begin
                valid_r[0] <= in_valid;
                wreg_r[0]  <= in_wreg;
                wd_r[0]    <= in_wd;
                wdata_r[0] <= in_wdata;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (flush) begin
                    valid_r[k] <= 1'b0;
                    wreg_r[k]  <= 1'b0;
                end else if (hold_s[k]) begin
                    valid_r[k] <= valid_r[k];
                end else if (hold_s[k-1]) begin
                    valid_r[k] <= 1'b0;
                    wreg_r[k]  <= 1'b0;
                end else begin
                    valid_r[k] <= valid_r[k-1];
                    wreg_r[k]  <= wreg_r[k-1];
                    wd_r[k]    <= wd_r[k-1];
                    wdata_r[k] <= wdata_r[k-1];
                end
            end
        end
    end

    // Count cycles in which the chain refuses input; saturates at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 32'd0;
        end else if (!ready_s) begin
            stall_cnt_r <= sat_inc32(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

    // A held last stage does not write, so each entry writes exactly once on release.
    assign wb_we    = valid_r[STAGES-1] & wreg_r[STAGES-1] & ~hold_s[STAGES-1];
    assign wb_wd    = wd_r[STAGES-1];
    assign wb_wdata = wdata_r[STAGES-1];

    // Candidate list for forwarding: execute input first, then stages young to old.
    always_comb begin
        cand_we_s    = {NCAND{1'b0}};
        cand_wd_s    = {(NCAND*AW){1'b0}};
        cand_wdata_s = {(NCAND*DW){1'b0}};
        cand_we_s[0]          = in_valid & in_wreg;
        cand_wd_s[0 +: AW]    = in_wd;
        cand_wdata_s[0 +: DW] = in_wdata;
        for (int k = 0; k < STAGES; k++) begin
            cand_we_s[k+1]              = valid_r[k] & wreg_r[k];
            cand_wd_s[(k+1)*AW +: AW]   = wd_r[k];
            cand_wdata_s[(k+1)*DW +: DW] = wdata_r[k];
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
        pipe_fwd_chain_fwd_mux #(
            .DW    (DW),
            .AW    (AW),
            .NCAND (NCAND)
        ) u_fwd_mux (
            .cand_we    (cand_we_s),
            .cand_wd    (cand_wd_s),
            .cand_wdata (cand_wdata_s),
            .raddr      (raddr[p*AW +: AW]),
            .rf_rdata   (rf_rdata[p*DW +: DW]),
            .rdata      (fwd_rdata[p*DW +: DW]),
            .hit        (fwd_hit[p])
        );
    end

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// Directed bench for pipe_fwd_chain (STAGES=3, DW=32, AW=5, two read ports).
module tb_pipe_fwd_chain;

    localparam logic [31:0] RF0 = 32'h0000_AAAA;
    localparam logic [31:0] RF1 = 32'h0000_BBBB;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_wreg;
    logic [4:0]  in_wd;
    logic [31:0] in_wdata;
    logic        in_ready;
    logic [2:0]  stall;
    logic        flush;
    logic [9:0]  raddr;
    logic [63:0] rf_rdata;
    logic [63:0] fwd_rdata;
    logic [1:0]  fwd_hit;
    logic        wb_we;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_fwd_chain #(.STAGES(3), .DW(32), .AW(5), .RD_PORTS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_wreg(in_wreg),
        .in_wd(in_wd), .in_wdata(in_wdata), .in_ready(in_ready),
        .stall(stall), .flush(flush), .raddr(raddr), .rf_rdata(rf_rdata),
        .fwd_rdata(fwd_rdata), .fwd_hit(fwd_hit), .wb_we(wb_we),
        .wb_wd(wb_wd), .wb_wdata(wb_wdata), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        iv;
        logic        iw;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [2:0]  st;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wd;
        logic [31:0] e_wdata;
        logic [1:0]  e_hit;
        logic [31:0] e_f0;
        logic [31:0] e_f1;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic iv, input logic iw, input logic [4:0] wd,
                       input logic [31:0] wdata, input logic [2:0] st, input logic fl,
                       input logic [4:0] ra0, input logic [4:0] ra1);
        in_valid = iv; in_wreg = iw; in_wd = wd; in_wdata = wdata;
        stall = st; flush = fl; raddr = {ra1, ra0};
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fwd(input string name, input logic [1:0] hit,
                           input logic [31:0] f0, input logic [31:0] f1);
        chk({name, "_hit"}, {30'd0, fwd_hit}, {30'd0, hit});
        chk({name, "_f0"}, fwd_rdata[31:0], f0);
        chk({name, "_f1"}, fwd_rdata[63:32], f1);
    endtask

    initial begin
        // iv iw wd wdata st fl ra0 ra1 | rdy we wd wdata hit f0 f1
        tbl[0]  = '{1'b1,1'b1,5'd3,32'h11,3'd0,1'b0,5'd3,5'd0, 1'b1,1'b0,5'd0,32'h0,    2'b01,32'h11,32'h0};
        tbl[1]  = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd3,5'd0, 1'b1,1'b0,5'd0,32'h0,    2'b01,32'h11,32'h0};
        tbl[2]  = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd3,5'd0, 1'b1,1'b0,5'd0,32'h0,    2'b01,32'h11,32'h0};
        tbl[3]  = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd3,5'd0, 1'b1,1'b1,5'd3,32'h11,   2'b01,32'h11,32'h0};
        tbl[4]  = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd3,5'd0, 1'b1,1'b0,5'd0,32'h0,    2'b00,RF0,   32'h0};
        tbl[5]  = '{1'b1,1'b1,5'd5,32'hA, 3'd0,1'b0,5'd5,5'd5, 1'b1,1'b0,5'd0,32'h0,    2'b11,32'hA, 32'hA};
        tbl[6]  = '{1'b1,1'b1,5'd5,32'hB, 3'd0,1'b0,5'd5,5'd5, 1'b1,1'b0,5'd0,32'h0,    2'b11,32'hB, 32'hB};
        tbl[7]  = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd5,5'd5, 1'b1,1'b0,5'd0,32'h0,    2'b11,32'hB, 32'hB};
        tbl[8]  = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd5,5'd5, 1'b1,1'b1,5'd5,32'hA,    2'b11,32'hB, 32'hB};
        tbl[9]  = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd5,5'd5, 1'b1,1'b1,5'd5,32'hB,    2'b11,32'hB, 32'hB};
        tbl[10] = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd5,5'd5, 1'b1,1'b0,5'd0,32'h0,    2'b00,RF0,   RF1};
        tbl[11] = '{1'b1,1'b1,5'd0,32'hFFFF,3'd0,1'b0,5'd0,5'd0,1'b1,1'b0,5'd0,32'h0,   2'b00,32'h0, 32'h0};
        tbl[12] = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd0,5'd0, 1'b1,1'b0,5'd0,32'h0,    2'b00,32'h0, 32'h0};
        tbl[13] = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd0,5'd0, 1'b1,1'b0,5'd0,32'h0,    2'b00,32'h0, 32'h0};
        tbl[14] = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd0,5'd0, 1'b1,1'b1,5'd0,32'hFFFF, 2'b00,32'h0, 32'h0};
        tbl[15] = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd0,5'd0, 1'b1,1'b0,5'd0,32'h0,    2'b00,32'h0, 32'h0};
        tbl[16] = '{1'b1,1'b0,5'd9,32'h99,3'd0,1'b0,5'd9,5'd9, 1'b1,1'b0,5'd0,32'h0,    2'b00,RF0,   RF1};
        tbl[17] = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd9,5'd9, 1'b1,1'b0,5'd0,32'h0,    2'b00,RF0,   RF1};
        tbl[18] = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd9,5'd9, 1'b1,1'b0,5'd0,32'h0,    2'b00,RF0,   RF1};
        tbl[19] = '{1'b0,1'b0,5'd0,32'h0, 3'd0,1'b0,5'd9,5'd9, 1'b1,1'b0,5'd0,32'h0,    2'b00,RF0,   RF1};

        rst = 1'b0;
        rf_rdata = {RF1, RF0};
        in_valid = 1'b0; in_wreg = 1'b0; in_wd = 5'd0; in_wdata = 32'd0;
        stall = 3'd0; flush = 1'b0; raddr = 10'd0;
        #3;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wd", {27'd0, wb_wd}, 32'd0);
        chk("rst_wdata", wb_wdata, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        chk("rst_hit", {30'd0, fwd_hit}, 32'd0);
        tick();
        rst = 1'b1;

        // Table: basic latency, youngest-wins, register zero, non-writing entry.
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].iv, tbl[i].iw, tbl[i].wd, tbl[i].wdata,
                tbl[i].st, tbl[i].fl, tbl[i].ra0, tbl[i].ra1);
            chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d_we", i), {31'd0, wb_we}, {31'd0, tbl[i].e_we});
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d_wd", i), {27'd0, wb_wd}, {27'd0, tbl[i].e_wd});
                chk($sformatf("v%0d_wdata", i), wb_wdata, tbl[i].e_wdata);
            end
            chk_fwd($sformatf("v%0d", i), tbl[i].e_hit, tbl[i].e_f0, tbl[i].e_f1);
            tick();
        end

        // Stall stage 1 for two cycles with three entries in flight.
        cyc(1'b1, 1'b1, 5'd1, 32'h101, 3'd0, 1'b0, 5'd0, 5'd0); tick();
        cyc(1'b1, 1'b1, 5'd2, 32'h202, 3'd0, 1'b0, 5'd0, 5'd0); tick();
        cyc(1'b1, 1'b1, 5'd4, 32'h404, 3'd0, 1'b0, 5'd0, 5'd0); tick();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 3'b010, 1'b0, 5'd2, 5'd1);
        chk("st0_ready", {31'd0, in_ready}, 32'd0);
        chk("st0_we", {31'd0, wb_we}, 32'd1);
        chk("st0_wd", {27'd0, wb_wd}, 32'd1);
        chk("st0_wdata", wb_wdata, 32'h101);
        chk_fwd("st0", 2'b11, 32'h202, 32'h101);
        tick();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 3'b010, 1'b0, 5'd4, 5'd1);
        chk("st1_ready", {31'd0, in_ready}, 32'd0);
        chk("st1_we", {31'd0, wb_we}, 32'd0);
        chk_fwd("st1", 2'b01, 32'h404, RF1);
        tick();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 5'd2, 5'd4);
        chk("st2_cnt", stall_cnt, 32'd2);
        chk("st2_ready", {31'd0, in_ready}, 32'd1);
        chk("st2_we", {31'd0, wb_we}, 32'd0);
        chk_fwd("st2", 2'b11, 32'h202, 32'h404);
        tick();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 5'd0, 5'd0);
        chk("st3_we", {31'd0, wb_we}, 32'd1);
        chk("st3_wd", {27'd0, wb_wd}, 32'd2);
        chk("st3_wdata", wb_wdata, 32'h202);
        tick();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 5'd0, 5'd0);
        chk("st4_we", {31'd0, wb_we}, 32'd1);
        chk("st4_wd", {27'd0, wb_wd}, 32'd4);
        chk("st4_wdata", wb_wdata, 32'h404);
        tick();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 5'd0, 5'd0);
        chk("st5_we", {31'd0, wb_we}, 32'd0);
        chk("st5_cnt", stall_cnt, 32'd2);
        tick();

        // Flush together with a full stall; the input presented then is dropped.
        cyc(1'b1, 1'b1, 5'd8, 32'h808, 3'd0, 1'b0, 5'd0, 5'd0); tick();
        cyc(1'b1, 1'b1, 5'd9, 32'h909, 3'd0, 1'b0, 5'd0, 5'd0); tick();
        cyc(1'b1, 1'b1, 5'd10, 32'hA0A, 3'd0, 1'b0, 5'd0, 5'd0); tick();
        cyc(1'b1, 1'b1, 5'd11, 32'hB0B, 3'b111, 1'b1, 5'd0, 5'd0);
        chk("fl0_ready", {31'd0, in_ready}, 32'd0);
        chk("fl0_we", {31'd0, wb_we}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, (i == 0) ? 5'd8 : 5'd11, 5'd10);
            chk($sformatf("fl%0d_we", i + 1), {31'd0, wb_we}, 32'd0);
            chk_fwd($sformatf("fl%0d", i + 1), 2'b00, RF0, RF1);
            if (i == 0) chk("fl1_cnt", stall_cnt, 32'd3);
            tick();
        end

        // Asynchronous reset while an r7 write sits in stage 1.
        cyc(1'b1, 1'b1, 5'd7, 32'h707, 3'd0, 1'b0, 5'd7, 5'd0); tick();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 5'd7, 5'd0); tick();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 5'd7, 5'd0);
        chk_fwd("rs_pre", 2'b01, 32'h707, 32'h0);
        rst = 1'b0;
        #1;
        chk("rs_we", {31'd0, wb_we}, 32'd0);
        chk("rs_cnt", stall_cnt, 32'd0);
        chk("rs_ready", {31'd0, in_ready}, 32'd1);
        chk_fwd("rs_mid", 2'b00, RF0, 32'h0);
        stall = 3'b100;
        #1;
        chk("rs_ready_stall", {31'd0, in_ready}, 32'd0);
        stall = 3'd0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 5'd7, 5'd0);
            chk($sformatf("rs%0d_we", i), {31'd0, wb_we}, 32'd0);
            chk_fwd($sformatf("rs%0d", i), 2'b00, RF0, 32'h0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
